// File: rtl/kuznechik_pkg.sv
// Shared Kuznechik definitions: round-key geometry and the key-store state encoding.
package kuznechik_pkg;

    localparam int KEY_W   = 128;
    localparam int N_RKEYS = 10;
    localparam int N_PAIRS = 5;

    typedef enum logic [1:0] {
        RKS_IDLE  = 2'd0,
        RKS_LOAD  = 2'd1,
        RKS_READY = 2'd2,
        RKS_ERROR = 2'd3
    } rks_state_t;

endpackage

// File: rtl/kuznechik_rkey_rf.sv
// Round-key pair register file: one 2*KEY_W write port, one registered KEY_W read port
// selecting the upper or lower half of a pair.
module kuznechik_rkey_rf #(
    parameter int KEY_W   = 128,
    parameter int N_PAIRS = 5,
    parameter int PTR_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_we,
    input  logic [PTR_W-1:0]   i_waddr,
    input  logic [2*KEY_W-1:0] i_wdata,
    input  logic               i_re,
    input  logic               i_rzero,
    input  logic [PTR_W-1:0]   i_raddr,
    input  logic               i_rupper,
    output logic [KEY_W-1:0]   o_rdata
);

    logic [2*KEY_W-1:0] r_mem [N_PAIRS];
    logic [KEY_W-1:0]   r_rdata;
    logic [2*KEY_W-1:0] w_pair;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PAIRS; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < N_PAIRS; i++) begin
                if (i_we && (i_waddr == PTR_W'(i))) r_mem[i] <= i_wdata;
            end
        end
    end

    // Out-of-range addresses read as zero rather than aliasing another pair.
    always_comb begin
        w_pair = '0;
        for (int i = 0; i < N_PAIRS; i++) begin
            if (i_raddr == PTR_W'(i)) w_pair = r_mem[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            if (i_rzero)       r_rdata <= '0;
            else if (i_rupper) r_rdata <= w_pair[2*KEY_W-1:KEY_W];
            else               r_rdata <= w_pair[KEY_W-1:0];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/kuznechik_rkey_store.sv
// Kuznechik round-key store: runs the key generator once, captures K1..K10 and serves
// them by round index in encrypt or decrypt order.
module kuznechik_rkey_store #(
    parameter int KEY_W   = kuznechik_pkg::KEY_W,
    parameter int N_PAIRS = kuznechik_pkg::N_PAIRS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               kg_en,
    input  logic               kg_valid,
    input  logic [2*KEY_W-1:0] kg_keys,
    input  logic               kg_done,
    output logic               keys_ready,
    input  logic               rd_req,
    input  logic               rd_dir,
    input  logic [3:0]         rd_idx,
    output logic               rd_valid,
    output logic [KEY_W-1:0]   rd_key,
    output logic               rd_err,
    output logic               err
);

    import kuznechik_pkg::*;

    localparam int N_KEYS = 2 * N_PAIRS;
    localparam int PTR_W  = (N_PAIRS > 1) ? $clog2(N_PAIRS + 1) : 1;
    localparam logic [PTR_W-1:0] LAST_PAIR = PTR_W'(N_PAIRS - 1);

    rks_state_t       r_state, w_state_nxt;
    logic [PTR_W-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic             w_we;
    logic             r_rd_valid, r_rd_err;
    logic             w_rd_legal;
    logic [3:0]       w_ord;

    // Zero-based key order: key n-1 where n = idx+1 (encrypt) or N_KEYS-idx (decrypt).
    function automatic logic [3:0] key_ord(input logic dir, input logic [3:0] idx);
        return dir ? (4'(N_KEYS - 1) - idx) : idx;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RKS_IDLE;
            r_wr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_we         = 1'b0;
        case (r_state)
            RKS_IDLE: begin
                if (start) begin
                    w_state_nxt  = RKS_LOAD;
                    w_wr_ptr_nxt = '0;
                end
            end
            RKS_LOAD: begin
                if (kg_valid) begin
                    w_we         = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                    if (r_wr_ptr == LAST_PAIR) w_state_nxt = kg_done ? RKS_READY : RKS_ERROR;
                    else if (kg_done)          w_state_nxt = RKS_ERROR;
                end else if (kg_done) begin
                    w_state_nxt = RKS_ERROR;
                end
            end
            // The generator only restarts on reset, so a stray pulse here is unrecoverable.
            RKS_READY: if (kg_valid) w_state_nxt = RKS_ERROR;
            RKS_ERROR: w_state_nxt = RKS_ERROR;
            default:   w_state_nxt = RKS_ERROR;
        endcase
    end

    assign kg_en      = (r_state == RKS_LOAD);
    assign keys_ready = (r_state == RKS_READY);
    assign err        = (r_state == RKS_ERROR);

    assign w_rd_legal = (r_state == RKS_READY) && (rd_idx < 4'(N_KEYS));
    assign w_ord      = key_ord(rd_dir, rd_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_valid <= rd_req;
            r_rd_err   <= rd_req & ~w_rd_legal;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_err   = r_rd_err;

    // Odd key numbers (even zero-based order) live in the upper half of their pair.
    kuznechik_rkey_rf #(
        .KEY_W   (KEY_W),
        .N_PAIRS (N_PAIRS),
        .PTR_W   (PTR_W)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (w_we),
        .i_waddr  (r_wr_ptr),
        .i_wdata  (kg_keys),
        .i_re     (rd_req),
        .i_rzero  (~w_rd_legal),
        .i_raddr  (PTR_W'(w_ord >> 1)),
        .i_rupper (~w_ord[0]),
        .o_rdata  (rd_key)
    );

endmodule

// File: tb/tb_kuznechik_rkey_store.sv
// Directed bench for kuznechik_rkey_store: a model generator replays the GOST round keys.
module tb_kuznechik_rkey_store;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         kg_en;
    logic         kg_valid;
    logic [255:0] kg_keys;
    logic         kg_done;
    logic         keys_ready;
    logic         rd_req;
    logic         rd_dir;
    logic [3:0]   rd_idx;
    logic         rd_valid;
    logic [127:0] rd_key;
    logic         rd_err;
    logic         err;

    int n_chk = 0;
    int n_err = 0;
    logic [127:0] rk [10];

    kuznechik_rkey_store #(.KEY_W(128), .N_PAIRS(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .kg_en      (kg_en),
        .kg_valid   (kg_valid),
        .kg_keys    (kg_keys),
        .kg_done    (kg_done),
        .keys_ready (keys_ready),
        .rd_req     (rd_req),
        .rd_dir     (rd_dir),
        .rd_idx     (rd_idx),
        .rd_valid   (rd_valid),
        .rd_key     (rd_key),
        .rd_err     (rd_err),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".kg_en"},      128'(kg_en),      128'd0);
        chk({tag, ".keys_ready"}, 128'(keys_ready), 128'd0);
        chk({tag, ".rd_valid"},   128'(rd_valid),   128'd0);
        chk({tag, ".rd_err"},     128'(rd_err),     128'd0);
        chk({tag, ".rd_key"},     rd_key,           128'd0);
        chk({tag, ".err"},        128'(err),        128'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Model generator: npulse pair strobes, one idle cycle before each, kg_done on pulse done_at.
    task automatic load(input int npulse, input int done_at);
        for (int p = 0; p < npulse; p++) begin
            tick();
            kg_valid = 1'b1;
            kg_keys  = {rk[2*p], rk[2*p+1]};
            kg_done  = (p == done_at);
            tick();
            kg_valid = 1'b0;
            kg_done  = 1'b0;
        end
    endtask

    task automatic rd_chk(input string tag, input logic dir, input logic [3:0] idx,
                          input logic exp_err, input logic [127:0] exp_key);
        rd_req = 1'b1;
        rd_dir = dir;
        rd_idx = idx;
        tick();
        rd_req = 1'b0;
        chk({tag, ".valid"}, 128'(rd_valid), 128'd1);
        chk({tag, ".err"},   128'(rd_err),   128'(exp_err));
        chk({tag, ".key"},   rd_key,         exp_key);
    endtask

    initial begin
        rk[0] = 128'h8899aabbccddeeff0011223344556677;
        rk[1] = 128'hfedcba98765432100123456789abcdef;
        rk[2] = 128'hdb31485315694343228d6aef8cc78c44;
        rk[3] = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
        rk[4] = 128'h57646468c44a5e28d3e59246f429f1ac;
        rk[5] = 128'hbd079435165c6432b532e82834da581b;
        rk[6] = 128'h51e640757e8745de705727265a0098b1;
        rk[7] = 128'h5a7925017b9fdd3ed72a91a22286f984;
        rk[8] = 128'hbb44e25378c73123a5f32f73cdb6e517;
        rk[9] = 128'h72e9dd7416bcf45b755dbaa88e4a4043;

        start = 0; kg_valid = 0; kg_keys = '0; kg_done = 0;
        rd_req = 0; rd_dir = 0; rd_idx = 0;
        do_reset();
        chk_reset_outs("rst");

        // Normal load with a read attempted while loading.
        do_start();
        chk("start.kg_en", 128'(kg_en), 128'd1);
        rd_chk("rd_load", 1'b0, 4'd0, 1'b1, 128'd0);
        chk("rd_load.no_err", 128'(err), 128'd0);
        load(5, 4);
        chk("done.keys_ready", 128'(keys_ready), 128'd1);
        chk("done.kg_en",      128'(kg_en),      128'd0);
        chk("done.err",        128'(err),        128'd0);

        rd_chk("enc0", 1'b0, 4'd0, 1'b0, rk[0]);
        rd_chk("enc2", 1'b0, 4'd2, 1'b0, rk[2]);
        rd_chk("enc9", 1'b0, 4'd9, 1'b0, rk[9]);
        rd_chk("dec0", 1'b1, 4'd0, 1'b0, rk[9]);
        rd_chk("dec9", 1'b1, 4'd9, 1'b0, rk[0]);

        // Ten back-to-back decrypt reads, then check that rd_key holds.
        for (int i = 0; i < 10; i++) begin
            rd_req = 1'b1; rd_dir = 1'b1; rd_idx = 4'(i);
            tick();
            chk("b2b_dec.valid", 128'(rd_valid), 128'd1);
            chk("b2b_dec.err",   128'(rd_err),   128'd0);
            chk("b2b_dec.key",   rd_key,         rk[9-i]);
        end
        rd_req = 1'b0;
        tick();
        chk("hold.valid", 128'(rd_valid), 128'd0);
        chk("hold.key",   rd_key,         rk[0]);

        rd_chk("idx12", 1'b0, 4'd12, 1'b1, 128'd0);
        rd_chk("idx10", 1'b1, 4'd10, 1'b1, 128'd0);
        chk("idx_bad.no_err", 128'(err), 128'd0);
        tick();
        chk("strobe_one_cycle", 128'(rd_err), 128'd0);

        do_start();
        chk("start_ready.kg_en", 128'(kg_en),      128'd0);
        chk("start_ready.kr",    128'(keys_ready), 128'd1);

        // Stray pulse after the load completed.
        kg_valid = 1'b1;
        tick();
        kg_valid = 1'b0;
        chk("extra.err", 128'(err),        128'd1);
        chk("extra.kr",  128'(keys_ready), 128'd0);
        chk("extra.en",  128'(kg_en),      128'd0);
        rd_chk("rd_error", 1'b0, 4'd1, 1'b1, 128'd0);

        // Early kg_done on the third pulse.
        do_reset();
        chk_reset_outs("rst2");
        do_start();
        load(3, 2);
        chk("early_done.err", 128'(err),   128'd1);
        chk("early_done.en",  128'(kg_en), 128'd0);

        // Fifth pulse without kg_done.
        do_reset();
        do_start();
        load(4, -1);
        chk("late4.err", 128'(err),   128'd0);
        chk("late4.en",  128'(kg_en), 128'd1);
        load(1, -1);
        chk("no_done.err", 128'(err),   128'd1);
        chk("no_done.en",  128'(kg_en), 128'd0);

        // Asynchronous reset in the middle of a load.
        do_reset();
        do_start();
        load(2, -1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rst_mid");
        tick();
        rst_n = 1'b1;
        rd_chk("rd_idle", 1'b0, 4'd0, 1'b1, 128'd0);
        do_start();
        chk("restart.kg_en", 128'(kg_en), 128'd1);
        load(5, 4);
        chk("reload.kr", 128'(keys_ready), 128'd1);
        for (int i = 0; i < 10; i++) begin
            rd_req = 1'b1; rd_dir = 1'b0; rd_idx = 4'(i);
            tick();
            chk("reload_enc.valid", 128'(rd_valid), 128'd1);
            chk("reload_enc.key",   rd_key,         rk[i]);
        end
        rd_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/kuznechik_rkey_store.md
# kuznechik_rkey_store

Round-key receiver and store for the Kuznechik core. Consumes the round-key pair stream from `kuznechik_keygen` (five 256-bit pulses carrying K1..K10) and gates its `en` so the generator runs exactly once. It holds all ten 128-bit round keys and serves them by round index to the cipher datapath, in encrypt order (K1 first) or decrypt order (K10 first).

## Interface
Parameters:
- `KEY_W`, 128: round-key width.
- `N_PAIRS`, 5: key pairs per generator run; key count is 2*`N_PAIRS`.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: begin a load; accepted only in IDLE.
- `kg_en`  out  1: generator enable; connects to keygen `en`.
- `kg_valid`  in  1: pair strobe; connects to keygen `ready`.
- `kg_keys`  in  2*KEY_W: pair; [255:128] = K(2p+1), [127:0] = K(2p+2).
- `kg_done`  in  1: connects to keygen `full_ready`.
- `keys_ready`  out  1: level; all ten keys stored.
- `rd_req`  in  1: read request.
- `rd_dir`  in  1: 0 = encrypt, 1 = decrypt.
- `rd_idx`  in  4: round index 0..9.
- `rd_valid`  out  1: one-cycle response strobe.
- `rd_key`  out  KEY_W: returned key.
- `rd_err`  out  1: one-cycle strobe with `rd_valid` on an illegal read.
- `err`  out  1: sticky protocol error.

## Operation
- States: IDLE, LOAD, READY, ERROR.
- IDLE: `kg_en`=0. `start` -> LOAD, `wr_ptr`<=0.
- LOAD: `kg_en`=1, combinationally decoded from state. On `kg_valid`: write `kg_keys` into pair slot `wr_ptr`, increment `wr_ptr`.
  - `kg_valid` with `wr_ptr`==N_PAIRS-1 and `kg_done`=1 -> READY.
  - `kg_valid` with `wr_ptr`==N_PAIRS-1 and `kg_done`=0 -> ERROR.
  - `kg_done`=1 at any other point -> ERROR.
- READY: `keys_ready`=1, `kg_en`=0. `kg_valid` -> ERROR; the key contents are kept.
- ERROR: `err`=1, `kg_en`=0, `keys_ready`=0. Exit only via `rst_n`, because the generator restarts only on reset.
- `start` outside IDLE is ignored.
- Index mapping: key number n = `rd_idx`+1 (encrypt) or 10-`rd_idx` (decrypt).
  - Storage slot for n: pair (n-1)>>1, upper half if n is odd.
- Illegal read: `rd_req` with `rd_idx`>9 or state != READY. Response is `rd_valid`=1, `rd_err`=1, `rd_key`=0. The read does not set `err`.

## Timing
- Reset values: state IDLE, `kg_en` 0, `keys_ready` 0, `rd_valid` 0, `rd_err` 0, `rd_key` 0, `err` 0, `wr_ptr` 0, all storage 0.
- `start` sampled at edge t -> `kg_en`=1 from t+1.
- The final `kg_valid` at edge t moves the state to READY at t. `kg_en` drops and `keys_ready` rises in cycle t+1, so the generator's wrapped counter never advances.
- Read latency is 1 cycle: `rd_req` at edge t -> `rd_valid` and `rd_key` registered at t, visible in cycle t+1.
  - Back-to-back requests give one response per cycle.
  - `rd_key` holds its value until the next response.
- `rd_req` in the same cycle as the READY transition is illegal (state is still LOAD).
- `rst_n` asserted mid-LOAD clears everything immediately. A partially loaded key is never readable.

## Structure
- Shared `kuznechik_pkg`: `KEY_W`, `N_RKEYS`=10, `N_PAIRS`=5, and the state enum `rks_state_t`.
- One sub-module, `kuznechik_rkey_rf`: a 5x256 register file with async-reset storage, a single write port, and a registered 128-bit read port with half select.
- The FSM, index mapping and error logic live in the top module.

## Test plan
- GOST vector: master key `8899aabbccddeeff0011223344556677_fedcba98765432100123456789abcdef` with a real keygen. `start` -> 5 pulses -> `keys_ready`=1, `kg_en`=0.
  - Encrypt reads: idx 0 -> `8899aabbccddeeff0011223344556677`, idx 2 -> `db31485315694343228d6aef8cc78c44`, idx 9 -> `72e9dd7416bcf45b755dbaa88e4a4043`.
- Decrypt reads: idx 0 -> `72e9dd74...4043`, idx 9 -> `8899aabb...6677`. Ten back-to-back requests give ten consecutive `rd_valid` cycles.
- Read with `rd_idx`=12 in READY, and any read in LOAD: `rd_valid`=1, `rd_err`=1, `rd_key`=0, `err` stays 0.
- Model generator drives `kg_done` on the 3rd pulse -> ERROR, `err`=1, `kg_en`=0. The 5th pulse without `kg_done` also -> ERROR.
- Extra `kg_valid` in READY -> `err`=1, `keys_ready`=0. `start` in READY is ignored, `kg_en` stays 0.
- `rst_n` pulse after the 2nd pulse: all outputs return to reset values. A fresh `start` then yields the correct keys.
